// File: rtl/prm_scan_pkg.sv
// Types and constants shared by the edge-scan controller and its helpers.
package prm_scan_pkg;
  localparam int CODE_W = 15;
  localparam int CNT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_EMIT    = 3'd3,
    ST_DONE    = 3'd4
  } scan_state_e;
endpackage

// File: rtl/prm_popcnt.sv
// Combinational population count of one edge_mask word.
module prm_popcnt #(
  parameter int GROUP_W = 16,
  parameter int OUT_W   = $clog2(GROUP_W + 1)
) (
  input  logic [GROUP_W-1:0] din,
  output logic [OUT_W-1:0]   cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < GROUP_W; i++) cnt = cnt + OUT_W'(din[i]);
  end
endmodule

// File: rtl/prm_edge_scan_ctrl.sv
// Walks every checker group for one obstacle code, streams each captured
// edge_mask word out and accumulates the total number of blocked edges.
module prm_edge_scan_ctrl
  import prm_scan_pkg::*;
#(
  parameter int NUM_GROUPS = 64,
  parameter int GROUP_W    = 16,
  parameter int CHK_LAT    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [CODE_W-1:0]             req_code,
  input  logic                          abort,
  output logic [CODE_W-1:0]             chk_code,
  output logic [$clog2(NUM_GROUPS)-1:0] chk_grp,
  input  logic [GROUP_W-1:0]            chk_mask,
  output logic                          mask_valid,
  input  logic                          mask_ready,
  output logic [$clog2(NUM_GROUPS)-1:0] mask_grp,
  output logic [GROUP_W-1:0]            mask_data,
  output logic [CNT_W-1:0]              blocked_cnt,
  output logic                          busy,
  output logic                          done
);
  localparam int GRP_W = $clog2(NUM_GROUPS);
  localparam int PC_W  = $clog2(GROUP_W + 1);
  localparam logic [GRP_W-1:0] GRP_LAST    = GRP_W'(NUM_GROUPS - 1);
  localparam logic [2:0]       SETTLE_LAST = 3'(CHK_LAT - 1);

  scan_state_e        state_q, state_d;
  logic [CODE_W-1:0]  chk_code_q, chk_code_d;
  logic [GRP_W-1:0]   chk_grp_q, chk_grp_d;
  logic [2:0]         settle_q, settle_d;
  logic [GROUP_W-1:0] mask_data_q, mask_data_d;
  logic [GRP_W-1:0]   mask_grp_q, mask_grp_d;
  logic [CNT_W-1:0]   blocked_q, blocked_d;
  logic [PC_W-1:0]    pop_cnt;

  prm_popcnt #(.GROUP_W(GROUP_W), .OUT_W(PC_W)) u_popcnt (
    .din (chk_mask),
    .cnt (pop_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      chk_code_q  <= '0;
      chk_grp_q   <= '0;
      settle_q    <= '0;
      mask_data_q <= '0;
      mask_grp_q  <= '0;
      blocked_q   <= '0;
    end else begin
      state_q     <= state_d;
      chk_code_q  <= chk_code_d;
      chk_grp_q   <= chk_grp_d;
      settle_q    <= settle_d;
      mask_data_q <= mask_data_d;
      mask_grp_q  <= mask_grp_d;
      blocked_q   <= blocked_d;
    end
  end

  // Abort wins over everything, including a same-cycle EMIT handshake.
  always_comb begin
    state_d     = state_q;
    chk_code_d  = chk_code_q;
    chk_grp_d   = chk_grp_q;
    settle_d    = settle_q;
    mask_data_d = mask_data_q;
    mask_grp_d  = mask_grp_q;
    blocked_d   = blocked_q;
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            state_d    = ST_SETTLE;
            chk_code_d = req_code;
            chk_grp_d  = '0;
            settle_d   = '0;
            blocked_d  = '0;
          end
        end
        ST_SETTLE: begin
          if (settle_q == SETTLE_LAST) state_d = ST_CAPTURE;
          else                         settle_d = settle_q + 3'd1;
        end
        ST_CAPTURE: begin
          mask_data_d = chk_mask;
          mask_grp_d  = chk_grp_q;
          blocked_d   = blocked_q + CNT_W'(pop_cnt);
          state_d     = ST_EMIT;
        end
        ST_EMIT: begin
          if (mask_ready) begin
            if (chk_grp_q == GRP_LAST) begin
              state_d = ST_DONE;
            end else begin
              chk_grp_d = chk_grp_q + GRP_W'(1);
              settle_d  = '0;
              state_d   = ST_SETTLE;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready  = 1'b0;
    busy       = 1'b1;
    mask_valid = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_EMIT: mask_valid = 1'b1;
      ST_DONE: done       = 1'b1;
      default: ;
    endcase
  end

  assign chk_code    = chk_code_q;
  assign chk_grp     = chk_grp_q;
  assign mask_data   = mask_data_q;
  assign mask_grp    = mask_grp_q;
  assign blocked_cnt = blocked_q;
endmodule

// File: doc/prm_edge_scan_ctrl.md
PRM_EDGE_SCAN_CTRL -- requirements
Module: prm_edge_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_GROUPS, default 64, meaning the number of edge-checker groups scanned per request (2..256).
REQ-002 SHALL have parameter GROUP_W, default 16, meaning the edge_mask bits per group; NUM_GROUPS*GROUP_W SHALL be < 65536.
REQ-003 SHALL have parameter CHK_LAT, default 1, meaning the settle cycles between a new chk_grp and sampling chk_mask (1..7).
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, 1, scan request with obstacle code.
REQ-007 SHALL have port req_ready, output, 1, high only in IDLE.
REQ-008 SHALL have port req_code, input, 15, obstacle code (bit0=A ... bit14=O).
REQ-009 SHALL have port abort, input, 1, cancels the scan in progress.
REQ-010 SHALL have port chk_code, output, 15, latched code driven to the checker bank.
REQ-011 SHALL have port chk_grp, output, clog2(NUM_GROUPS), selected checker group.
REQ-012 SHALL have port chk_mask, input, GROUP_W, edge_mask bits of the selected group.
REQ-013 SHALL have port mask_valid, output, 1, mask word available.
REQ-014 SHALL have port mask_ready, input, 1, consumer accepts the mask word.
REQ-015 SHALL have port mask_grp, output, clog2(NUM_GROUPS), group index of mask_data.
REQ-016 SHALL have port mask_data, output, GROUP_W, captured edge_mask word.
REQ-017 SHALL have port blocked_cnt, output, 16, total set edge_mask bits of the current/last scan.
REQ-018 SHALL have ports busy, output, 1 (not IDLE) and done, output, 1 (one-cycle completion pulse).

Function
REQ-019 SHALL implement states IDLE, SETTLE, CAPTURE, EMIT, DONE.
REQ-020 SHALL, in IDLE with req_valid=1, latch req_code into chk_code, set chk_grp=0, clear blocked_cnt and the settle counter, and enter SETTLE.
REQ-021 SHALL hold SETTLE for exactly CHK_LAT cycles, then enter CAPTURE.
REQ-022 SHALL, in CAPTURE (one cycle), register chk_mask into mask_data, set mask_grp=chk_grp, add popcount(chk_mask) to blocked_cnt, and enter EMIT.
REQ-023 SHALL assert mask_valid only in EMIT, holding mask_data/mask_grp stable until mask_valid&mask_ready.
REQ-024 SHALL, on the EMIT handshake, enter DONE if chk_grp==NUM_GROUPS-1, else increment chk_grp and enter SETTLE.
REQ-025 SHALL pulse done for the single DONE cycle, then return to IDLE; blocked_cnt SHALL hold until the next accepted request.
REQ-026 SHALL keep chk_code and chk_grp constant during SETTLE, CAPTURE and EMIT.
REQ-027 SHALL, when abort=1 in any non-IDLE state, return to IDLE next cycle with mask_valid=0 and no done pulse; abort takes priority over a same-cycle EMIT handshake; abort in IDLE is ignored and does not block a same-cycle request.
REQ-028 SHALL ignore req_valid outside IDLE (req_ready=0).
REQ-029 SHALL compute blocked_cnt without saturation (bounded by REQ-002).
REQ-030 SHALL give per-group scan latency CHK_LAT+2 cycles plus EMIT backpressure; full scan with mask_ready tied high is NUM_GROUPS*(CHK_LAT+2)+1 cycles from accept to done.

Reset
REQ-031 SHALL, on rst_n=0 asynchronously, enter IDLE with chk_code=0, chk_grp=0, mask_data=0, mask_grp=0, blocked_cnt=0, mask_valid=0, done=0, busy=0, req_ready=1 after release.
REQ-032 SHALL discard a scan in progress on reset, producing no further mask words or done.

Structure
REQ-033 SHALL place the state enumeration and CODE_W=15 in shared package prm_scan_pkg.
REQ-034 SHALL implement popcount as sub-module prm_popcnt (GROUP_W in, clog2(GROUP_W+1) out, combinational).

Verification
REQ-035 SHALL cover: NUM_GROUPS=4, CHK_LAT=1, mask_ready=1, code 0x4A5B, checker model returning 0x0003 per group -> 4 mask words grp 0..3, chk_code=0x4A5B throughout, blocked_cnt=8, done at cycle 13 after accept.
REQ-036 SHALL cover: mask_ready low 5 cycles in group 2 -> mask_valid held, mask_data/mask_grp stable, chk_grp stays 2.
REQ-037 SHALL cover: abort asserted in SETTLE of group 1 -> IDLE next cycle, no done, req_ready=1, new request accepted and blocked_cnt restarts at 0.
REQ-038 SHALL cover: all-ones chk_mask, NUM_GROUPS=64, GROUP_W=16 -> blocked_cnt=1024 at done.
REQ-039 SHALL cover: rst_n low mid-EMIT -> all outputs at reset values immediately, no done after release.
REQ-040 SHALL cover: req_valid held high across done -> next scan accepted in the IDLE cycle after DONE; CHK_LAT=3 -> chk_mask sampled exactly 3 cycles after each chk_grp change.
